// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic engines.
package serial_arith_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder slice used by the serial adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder slice plus carry flop, start/done handshake.
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t             state, state_d;
   logic [WIDTH-1:0]   a_sr, a_d;
   logic [WIDTH-1:0]   b_sr, b_d;
   logic [WIDTH-1:0]   sum_d;
   logic               carry, carry_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic               cout_d, ovf_d, busy_d, done_d;
   logic               fa_s, fa_co;

   full_adder u_fa (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_co)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sr  <= '0;
         b_sr  <= '0;
         sum   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_d;
         a_sr  <= a_d;
         b_sr  <= b_d;
         sum   <= sum_d;
         carry <= carry_d;
         cnt   <= cnt_d;
         cout  <= cout_d;
         ovf   <= ovf_d;
         busy  <= busy_d;
         done  <= done_d;
      end
   end

   // Next-state and datapath update; sum bits enter at the MSB so the word lands aligned after WIDTH shifts.
   always_comb begin
      state_d = state;
      a_d     = a_sr;
      b_d     = b_sr;
      sum_d   = sum;
      carry_d = carry;
      cnt_d   = cnt;
      cout_d  = cout;
      ovf_d   = ovf;

      case (state)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
            end
         end
         SHIFT: begin
            a_d     = a_sr >> 1;
            b_d     = b_sr >> 1;
            sum_d   = {fa_s, sum[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
               // Signed overflow: carry into the MSB differs from carry out of it.
               ovf_d   = carry ^ fa_co;
               cout_d  = fa_co;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases plus a random sweep against integer addition.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a, b;
   logic         cin;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation, wait for done, compare against plain integer arithmetic.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input bit check_busy);
      logic [W:0] full;
      logic       exp_ovf;
      int         n;
      int         busy_cycles;
      full    = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
      exp_ovf = (ta[W-1] == tb_v[W-1]) && (full[W-1] != ta[W-1]);
      a = ta; b = tb_v; cin = tc; start = 1'b1;
      step();
      start = 1'b0;
      a = $urandom; b = $urandom; cin = 1'($urandom);
      n = 0;
      busy_cycles = (busy === 1'b1) ? 1 : 0;
      while (done !== 1'b1 && n < 40) begin
         step();
         n++;
         if (busy === 1'b1) busy_cycles++;
      end
      if (check_busy) begin
         chk("latency", 32'(n), 32'(W));
         chk("busy_cycles", 32'(busy_cycles), 32'(W + 1));
      end else if (n != W) begin
         chk("latency", 32'(n), 32'(W));
      end
      chk("sum", 32'(sum), 32'(full[W-1:0]));
      chk("cout", 32'(cout), 32'(full[W]));
      chk("ovf", 32'(ovf), 32'(exp_ovf));
      step();
      if (check_busy) begin
         chk("done_pulse_end", 32'(done), 32'(0));
         chk("idle_busy", 32'(busy), 32'(0));
         chk("sum_hold", 32'(sum), 32'(full[W-1:0]));
      end
   endtask

   initial begin
      int pulses;
      int last_done;
      logic [W:0] full;

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
      step(); step();
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_sum", 32'(sum), 32'(0));
      chk("rst_cout", 32'(cout), 32'(0));
      chk("rst_ovf", 32'(ovf), 32'(0));
      rst_n = 1'b1;
      step();

      // Plan 1-3: zero, carry and overflow corners.
      run_op(8'h00, 8'h00, 1'b0, 1'b1);
      run_op(8'hFF, 8'h01, 1'b0, 1'b1);
      run_op(8'h0F, 8'hF0, 1'b1, 1'b1);
      run_op(8'h7F, 8'h01, 1'b0, 1'b1);
      run_op(8'h80, 8'h80, 1'b0, 1'b1);

      // Plan 4: start while busy is ignored.
      a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      pulses = 0;
      for (int i = 1; i <= W + 6; i++) begin
         if (i == 3) begin
            a = 8'hFF; b = 8'hFF; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            pulses++;
            chk("busy_start_sum", 32'(sum), 32'h46);
            chk("busy_start_cout", 32'(cout), 32'(0));
         end
         step();
      end
      start = 1'b0;
      chk("busy_start_pulses", 32'(pulses), 32'(1));
      step(); step();

      // Plan 5: reset mid-operation aborts without a done pulse.
      a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_sum", 32'(sum), 32'(0));
      chk("abort_cout", 32'(cout), 32'(0));
      chk("abort_ovf", 32'(ovf), 32'(0));
      pulses = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (done === 1'b1) pulses++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < W + 3; i++) begin
         step();
         if (done === 1'b1) pulses++;
      end
      chk("abort_no_done", 32'(pulses), 32'(0));
      run_op(8'h01, 8'h02, 1'b1, 1'b1);

      // Plan 6: start held high gives back-to-back operations every W+2 cycles.
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      pulses = 0;
      last_done = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (done === 1'b1) begin
            pulses++;
            chk("held_sum", 32'(sum), 32'h30);
            if (last_done >= 0) chk("held_period", 32'(i - last_done), 32'(W + 2));
            last_done = i;
         end
      end
      start = 1'b0;
      chk("held_pulses", 32'(pulses), 32'(4));
      for (int i = 0; i < W + 3; i++) step();
      chk("held_idle", 32'(busy), 32'(0));

      // Random sweep.
      for (int i = 0; i < 1000; i++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      end

      // Golden equality of {cout,sum} after the last random op, with an explicit vector.
      run_op(8'hC3, 8'h5A, 1'b1, 1'b0);
      full = {cout, sum};
      chk("final_full", 32'(full), 32'(9'h11E));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
